// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the multi-lane FIFO: pointer/count widths and lane slice offsets.
// Pure package: no logic, no latency, no flow control.
package fifo_pkg;

    localparam int DEF_BW        = 8;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 14;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

    // Count needs one extra bit to represent a completely full lane.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// One FIFO lane: memory, pointers, occupancy count, registered read output, optional sticky errors (FIFO_ERR_EN).
// Latency: rd at edge N -> dout/valid after edge N; data written at edge N readable at edge N+1.
// Backpressure: writes to a full lane are dropped unless a read is accepted in the same cycle.
module fifo_lane
    import fifo_pkg::*;
#(
    parameter int bw        = DEF_BW,
    parameter int depth     = DEF_DEPTH,
    parameter int af_thresh = DEF_AF_THRESH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bw-1:0]           din,
    input  logic                    wr,
    input  logic                    rd,
    output logic [bw-1:0]           dout,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic                    afull,
    output logic [cnt_w(depth)-1:0] count,
    output logic                    ovf,
    output logic                    unf
);
    localparam int PW = ptr_w(depth);
    localparam int CW = cnt_w(depth);

    logic [bw-1:0] mem [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          rd_acc;
    logic          wr_acc;

    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(depth));
    assign afull  = (cnt >= CW'(af_thresh));
    assign count  = cnt;
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    // Storage is never cleared; reset only makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout   <= '0;
            valid  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout   <= mem[rd_ptr];
            end
            valid <= rd_acc;
            if (wr_acc && !rd_acc)      cnt <= cnt + CW'(1);
            else if (rd_acc && !wr_acc) cnt <= cnt - CW'(1);
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr && !wr_acc) ovf <= 1'b1;
            if (rd && empty)   unf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/fifo_array_top.sv
// Multi-lane synchronous FIFO: `width` independent fifo_lane instances; FIFO_ERR_EN enables sticky ovf/unf flags.
// Latency: one cycle from accepted rd to out/o_valid; write-to-read one cycle.
// Backpressure: per-lane o_ready (= ~o_full); o_all_ready is the AND across lanes.
module fifo_array_top
    import fifo_pkg::*;
#(
    parameter int bw        = DEF_BW,
    parameter int width     = DEF_WIDTH,
    parameter int depth     = DEF_DEPTH,
    parameter int af_thresh = DEF_AF_THRESH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [width*bw-1:0]           in,
    input  logic [width-1:0]              wr,
    input  logic [width-1:0]              rd,
    output logic [width*bw-1:0]           out,
    output logic [width-1:0]              o_valid,
    output logic [width-1:0]              o_full,
    output logic [width-1:0]              o_empty,
    output logic [width-1:0]              o_ready,
    output logic [width-1:0]              o_afull,
    output logic                          o_all_ready,
    output logic [width*cnt_w(depth)-1:0] o_count,
    output logic [width-1:0]              o_ovf,
    output logic [width-1:0]              o_unf
);
    localparam int CW = cnt_w(depth);

    for (genvar i = 0; i < width; i++) begin : g_lane
        fifo_lane #(
            .bw       (bw),
            .depth    (depth),
            .af_thresh(af_thresh)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .din  (in[lane_lsb(i, bw) +: bw]),
            .wr   (wr[i]),
            .rd   (rd[i]),
            .dout (out[lane_lsb(i, bw) +: bw]),
            .valid(o_valid[i]),
            .full (o_full[i]),
            .empty(o_empty[i]),
            .afull(o_afull[i]),
            .count(o_count[lane_lsb(i, CW) +: CW]),
            .ovf  (o_ovf[i]),
            .unf  (o_unf[i])
        );
    end

    assign o_ready     = ~o_full;
    assign o_all_ready = &o_ready;

endmodule
